sensor_clk_gen: RTL and testbench

Parametrised multi-channel sensor strobe/clock generator clocked from the 3.125 MHz system clock. A shared programmable modulo-N counter drives NUM_CH outputs. Each output has its own phase offset and either single-cycle pulse mode or square-wave mode. Divider and phase settings are reloaded glitch-free at the period boundary; a sync input realigns all channels to an external event. It replaces the fixed /20 sensor clock divider in the sensor front end.

---
 rtl/sensor_clk_gen.sv | 137 +++++++++++++
 tb/tb_sensor_clk_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_clk_gen.sv
// Multi-channel sensor strobe/clock generator: one shared modulo-N counter drives
// NUM_CH outputs, each with its own phase offset and pulse/square mode.
module sensor_clk_gen #(
  parameter int CNT_W       = 8,
  parameter int NUM_CH      = 2,
  parameter int DEFAULT_DIV = 100
) (
  input  logic                      clk_3M,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [CNT_W-1:0]          div_value,
  input  logic [NUM_CH*CNT_W-1:0]   ch_phase,
  input  logic [NUM_CH-1:0]         ch_mode,
  input  logic                      cfg_load,
  input  logic                      sync,
  output logic [NUM_CH-1:0]         ch_out,
  output logic                      period_tick,
  output logic [CNT_W-1:0]          cnt,
  output logic                      cfg_pending
);

  typedef logic [CNT_W-1:0] val_t;
  typedef logic [CNT_W:0]   wide_t;
  typedef enum logic {ST_HOLD, ST_RUN} state_t;

  localparam val_t DIV_RST = val_t'(DEFAULT_DIV);
  localparam val_t DIV_MIN = val_t'(2);
  localparam val_t ONE     = val_t'(1);

  state_t              state_q, state_nxt;
  val_t                cnt_q, cnt_nxt;
  val_t                div_act, div_nxt, div_pend, div_cap;
  val_t                ph_act  [NUM_CH];
  val_t                ph_nxt  [NUM_CH];
  val_t                ph_pend [NUM_CH];
  val_t                ph_cap  [NUM_CH];
  logic [NUM_CH-1:0]   mode_act, mode_nxt, mode_pend;
  logic [NUM_CH-1:0]   out_nxt;
  logic                pend_q, pend_nxt, tick_nxt;
  logic                apply_pend, apply_cap;
  wide_t               n_w, ph_w, sum_w, d_w;

  always_comb begin
    div_cap = (div_value < DIV_MIN) ? DIV_MIN : div_value;
    for (int unsigned k = 0; k < NUM_CH; k++)
      ph_cap[k] = ch_phase[k*CNT_W +: CNT_W];
  end

  // The first enabled edge after a hold restarts at 0 so a full period
  // (including the cnt==0 slot) is produced once outputs are allowed again.
  always_comb begin
    state_nxt  = enable ? ST_RUN : ST_HOLD;
    cnt_nxt    = '0;
    apply_pend = 1'b0;
    apply_cap  = 1'b0;
    if (!enable) begin
      apply_pend = pend_q;
    end else if (sync) begin
      if (cfg_load) apply_cap = 1'b1;
      else          apply_pend = pend_q;
    end else if (state_q == ST_RUN) begin
      if (cnt_q == div_act - ONE) apply_pend = pend_q;
      else                        cnt_nxt    = cnt_q + ONE;
    end

    div_nxt  = div_act;
    ph_nxt   = ph_act;
    mode_nxt = mode_act;
    if (apply_cap) begin
      div_nxt  = div_cap;
      ph_nxt   = ph_cap;
      mode_nxt = ch_mode;
    end else if (apply_pend) begin
      div_nxt  = div_pend;
      ph_nxt   = ph_pend;
      mode_nxt = mode_pend;
    end

    pend_nxt = pend_q;
    if (apply_pend || apply_cap) pend_nxt = 1'b0;
    if (cfg_load && !apply_cap)  pend_nxt = 1'b1;
  end

  // Outputs are derived from the next-state count/config so they line up with cnt.
  always_comb begin
    n_w     = {1'b0, div_nxt};
    ph_w    = '0;
    sum_w   = '0;
    d_w     = '0;
    out_nxt = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      ph_w  = (ph_nxt[k] >= div_nxt) ? {1'b0, div_nxt - ONE} : {1'b0, ph_nxt[k]};
      sum_w = {1'b0, cnt_nxt} + n_w - ph_w;
      d_w   = (sum_w >= n_w) ? sum_w - n_w : sum_w;
      out_nxt[k] = enable & (mode_nxt[k] ? (d_w < (n_w >> 1)) : (d_w == '0));
    end
    tick_nxt = enable & (cnt_nxt == div_nxt - ONE);
  end

  always_ff @(posedge clk_3M or posedge reset) begin
    if (reset) begin
      state_q     <= ST_HOLD;
      cnt_q       <= '0;
      div_act     <= DIV_RST;
      ph_act      <= '{default: '0};
      mode_act    <= '0;
      pend_q      <= 1'b0;
      ch_out      <= '0;
      period_tick <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      div_act     <= div_nxt;
      ph_act      <= ph_nxt;
      mode_act    <= mode_nxt;
      pend_q      <= pend_nxt;
      ch_out      <= out_nxt;
      period_tick <= tick_nxt;
    end
  end

  always_ff @(posedge clk_3M or posedge reset) begin
    if (reset) begin
      div_pend  <= DIV_RST;
      ph_pend   <= '{default: '0};
      mode_pend <= '0;
    end else if (cfg_load) begin
      div_pend  <= div_cap;
      ph_pend   <= ph_cap;
      mode_pend <= ch_mode;
    end
  end

  assign cnt         = cnt_q;
  assign cfg_pending = pend_q;

endmodule

// File: tb/tb_sensor_clk_gen.sv
// Self-checking bench for sensor_clk_gen: cycle scoreboard against a reference
// model, a table of per-config output patterns, and hand-written corner sequences.
`timescale 1ns/1ps
module tb_sensor_clk_gen;

  logic        clk_3M = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        cfg_load = 1'b0;
  logic        sync = 1'b0;
  logic [7:0]  div_value = '0;
  logic [15:0] ch_phase = '0;
  logic [1:0]  ch_mode = '0;
  logic [1:0]  ch_out;
  logic        period_tick;
  logic [7:0]  cnt;
  logic        cfg_pending;

  int checks = 0;
  int errors = 0;

  sensor_clk_gen #(.CNT_W(8), .NUM_CH(2), .DEFAULT_DIV(100)) dut (
    .clk_3M(clk_3M), .reset(reset), .enable(enable), .div_value(div_value),
    .ch_phase(ch_phase), .ch_mode(ch_mode), .cfg_load(cfg_load), .sync(sync),
    .ch_out(ch_out), .period_tick(period_tick), .cnt(cnt), .cfg_pending(cfg_pending)
  );

  always #160 clk_3M = ~clk_3M;

  typedef struct packed {
    logic [7:0] cnt;
    logic [1:0] ch;
    logic       tick;
    logic       pend;
  } obs_t;
  obs_t sb_q[$];

  int       m_cnt, m_n, m_pn;
  int       m_ph[2];
  int       m_pph[2];
  bit [1:0] m_mode, m_pmode;
  bit       m_pend, m_run;

  task automatic model_reset();
    m_cnt = 0; m_n = 100; m_pn = 100;
    m_ph[0] = 0; m_ph[1] = 0; m_pph[0] = 0; m_pph[1] = 0;
    m_mode = '0; m_pmode = '0; m_pend = 0; m_run = 0;
  endtask

  function automatic bit exp_ch(int c, int n, int ph, bit sq);
    int p;
    p = (ph >= n) ? n - 1 : ph;
    if (!sq) return c == p;
    for (int j = 0; j < n / 2; j++)
      if ((p + j) % n == c) return 1;
    return 0;
  endfunction

  task automatic model_step(output obs_t e);
    int nc;
    int din;
    bit app_p, app_i;
    app_p = 0; app_i = 0; nc = 0;
    din = (div_value < 2) ? 2 : int'(div_value);
    if (!enable) app_p = m_pend;
    else if (sync) begin
      if (cfg_load) app_i = 1; else app_p = m_pend;
    end else if (!m_run) nc = 0;
    else if (m_cnt == m_n - 1) app_p = m_pend;
    else nc = m_cnt + 1;
    if (app_p) begin m_n = m_pn; m_ph = m_pph; m_mode = m_pmode; m_pend = 0; end
    if (app_i) begin
      m_n = din; m_ph[0] = int'(ch_phase[7:0]); m_ph[1] = int'(ch_phase[15:8]);
      m_mode = ch_mode; m_pend = 0;
    end
    if (cfg_load && !app_i) begin
      m_pn = din; m_pph[0] = int'(ch_phase[7:0]); m_pph[1] = int'(ch_phase[15:8]);
      m_pmode = ch_mode; m_pend = 1;
    end
    m_cnt = nc; m_run = enable;
    e.cnt  = 8'(nc);
    e.tick = enable && (nc == m_n - 1);
    e.pend = m_pend;
    for (int k = 0; k < 2; k++) e.ch[k] = enable && exp_ch(nc, m_n, m_ph[k], m_mode[k]);
  endtask

  task automatic tick();
    obs_t e, a;
    model_step(e);
    sb_q.push_back(e);
    @(posedge clk_3M); #1;
    a.cnt = cnt; a.ch = ch_out; a.tick = period_tick; a.pend = cfg_pending;
    e = sb_q.pop_front();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL sb cnt/ch/tick/pend act %0d/%b/%b/%b exp %0d/%b/%b/%b at %0t",
               a.cnt, a.ch, a.tick, a.pend, e.cnt, e.ch, e.tick, e.pend, $time);
    end
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act %0d exp %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    int          div;
    int          ph0;
    int          ph1;
    logic [1:0]  mode;
    int          n;
    logic [31:0] pat0;
    logic [31:0] pat1;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int pcount, p0, p1, idx;
    logic [31:0] pat;

    // bit i of pat = expected output while cnt == i
    vecs[0] = '{div: 5,  ph0: 3,   ph1: 0,  mode: 2'b01, n: 5,  pat0: 32'h18,    pat1: 32'h1};
    vecs[1] = '{div: 2,  ph0: 0,   ph1: 1,  mode: 2'b11, n: 2,  pat0: 32'h1,     pat1: 32'h2};
    vecs[2] = '{div: 0,  ph0: 0,   ph1: 50, mode: 2'b00, n: 2,  pat0: 32'h1,     pat1: 32'h2};
    vecs[3] = '{div: 20, ph0: 50,  ph1: 5,  mode: 2'b00, n: 20, pat0: 32'h80000, pat1: 32'h20};
    vecs[4] = '{div: 8,  ph0: 2,   ph1: 6,  mode: 2'b11, n: 8,  pat0: 32'h3C,    pat1: 32'hC3};
    vecs[5] = '{div: 3,  ph0: 255, ph1: 1,  mode: 2'b10, n: 3,  pat0: 32'h4,     pat1: 32'h2};

    model_reset();
    #5;
    chk("rst_cnt", int'(cnt), 0);
    chk("rst_ch", int'(ch_out), 0);
    chk("rst_tick", int'(period_tick), 0);
    chk("rst_pend", int'(cfg_pending), 0);
    @(posedge clk_3M); #1;
    reset = 1'b0;
    enable = 1'b1;

    // defaults: N=100, both channels pulse at cnt 0
    tick();
    chk("first_cnt", int'(cnt), 0);
    chk("first_ch", int'(ch_out), 3);
    ticks(99);
    chk("def_cnt99", int'(cnt), 99);
    chk("def_tick99", int'(period_tick), 1);
    tick();
    chk("def_wrap_ch", int'(ch_out), 3);

    // mid-period load at cnt 40: old period completes
    ticks(40);
    chk("load_at", int'(cnt), 40);
    div_value = 8'd20; ch_phase = {8'd5, 8'd19}; ch_mode = 2'b00; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("load_pend", int'(cfg_pending), 1);
    pcount = 1;
    for (int i = 0; i < 200 && cnt != 0; i++) begin
      tick();
      if (cfg_pending) pcount++;
    end
    chk("load_wrap_cnt", int'(cnt), 0);
    chk("load_pend_cycles", pcount, 59);
    p0 = 0; p1 = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ch_out[0]) begin p0++; chk("ch0_pulse_cnt", int'(cnt), 19); end
      if (ch_out[1]) begin p1++; chk("ch1_pulse_cnt", int'(cnt), 5); end
    end
    chk("ch0_pulses", p0, 2);
    chk("ch1_pulses", p1, 2);

    // sync at cnt 7 with N=10 pending
    ticks(3);
    div_value = 8'd10; ch_phase = '0; ch_mode = 2'b00; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    ticks(3);
    chk("sync_at", int'(cnt), 7);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    chk("sync_cnt", int'(cnt), 0);
    chk("sync_pend", int'(cfg_pending), 0);
    chk("sync_ch", int'(ch_out), 3);
    ticks(9);
    chk("sync_n10_tick", int'(period_tick), 1);

    // table: immediate apply via sync+load, then two full periods
    foreach (vecs[v]) begin
      div_value = 8'(vecs[v].div);
      ch_phase  = {8'(vecs[v].ph1), 8'(vecs[v].ph0)};
      ch_mode   = vecs[v].mode;
      cfg_load = 1'b1; sync = 1'b1;
      tick();
      cfg_load = 1'b0; sync = 1'b0;
      for (int i = 0; i < 2 * vecs[v].n; i++) begin
        if (i > 0) tick();
        idx = i % vecs[v].n;
        chk("tbl_cnt", int'(cnt), idx);
        pat = vecs[v].pat0;
        chk("tbl_ch0", int'(ch_out[0]), int'(pat[idx]));
        pat = vecs[v].pat1;
        chk("tbl_ch1", int'(ch_out[1]), int'(pat[idx]));
        chk("tbl_tick", int'(period_tick), (idx == vecs[v].n - 1) ? 1 : 0);
      end
    end

    // async reset at cnt 57 with ch0 square, then 3 disabled cycles
    div_value = 8'd100; ch_phase = {8'd0, 8'd30}; ch_mode = 2'b01;
    cfg_load = 1'b1; sync = 1'b1;
    tick();
    cfg_load = 1'b0; sync = 1'b0;
    ticks(57);
    chk("pre_rst_cnt", int'(cnt), 57);
    chk("pre_rst_ch", int'(ch_out), 1);
    #50;
    reset = 1'b1;
    model_reset();
    #1;
    chk("arst_cnt", int'(cnt), 0);
    chk("arst_ch", int'(ch_out), 0);
    chk("arst_tick", int'(period_tick), 0);
    @(posedge clk_3M); #1;
    reset = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dis_ch", int'(ch_out), 0);
    end
    enable = 1'b1;
    tick();
    chk("reen_cnt", int'(cnt), 0);
    chk("reen_ch", int'(ch_out), 3);

    // randomized traffic against the scoreboard
    for (int i = 0; i < 1500; i++) begin
      enable    = ($urandom_range(0, 19) != 0);
      sync      = ($urandom_range(0, 29) == 0);
      cfg_load  = ($urandom_range(0, 9) == 0);
      div_value = 8'($urandom_range(0, 12));
      ch_phase  = {8'($urandom_range(0, 14)), 8'($urandom_range(0, 14))};
      ch_mode   = 2'($urandom_range(0, 3));
      tick();
    end
    enable = 1'b1; sync = 1'b0; cfg_load = 1'b0;
    ticks(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
